// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings and sequencer state type for the ALU self-test sweep.
package alu_seq_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_NAND = 2'b10;
    localparam logic [1:0] OP_ROL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10,
        DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Control/result bundle of the sweep top; the consumer drives start and observes the rest.
interface alu_seq_if #(
    parameter int WIDTH = 7
);
    logic             start;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [1:0]       OP;
    logic [WIDTH-1:0] R;
    logic             r_valid;
    logic             carry;
    logic             zero;
    logic [WIDTH-1:0] sig;
    logic             flag;

    modport master (
        output start,
        input  busy, done, A, B, OP, R, r_valid, carry, zero, sig, flag
    );

    modport slave (
        input  start,
        output busy, done, A, B, OP, R, r_valid, carry, zero, sig, flag
    );
endinterface

// File: rtl/alu_core.sv
// Combinational WIDTH-bit ALU: ADD, SUB (carry = borrow), NAND, rotate-left by B mod WIDTH.
module alu_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 7
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       OP,
    output logic [WIDTH-1:0] R,
    output logic             carry
);
    localparam int SH_W = $clog2(WIDTH);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [SH_W-1:0]  sh;

    assign sum  = {1'b0, A} + {1'b0, B};
    // Top bit of the widened difference is set exactly when A < B.
    assign diff = {1'b0, A} - {1'b0, B};
    assign sh   = SH_W'(B % WIDTH);

    always_comb begin
        R     = '0;
        carry = 1'b0;
        case (OP)
            OP_ADD: begin
                R     = sum[WIDTH-1:0];
                carry = sum[WIDTH];
            end
            OP_SUB: begin
                R     = diff[WIDTH-1:0];
                carry = diff[WIDTH];
            end
            OP_NAND: R = ~(A & B);
            OP_ROL:  R = (A << sh) | (A >> (WIDTH - sh));
            default: R = '0;
        endcase
    end
endmodule

// File: rtl/alu_seq_top.sv
// Sweeps all four opcodes over NUM_VEC generated operand pairs, registers each result and folds it into a rotating signature.
module alu_seq_top
    import alu_seq_pkg::*;
#(
    parameter int               WIDTH   = 7,
    parameter int               NUM_VEC = 16,
    parameter logic [WIDTH-1:0] A0      = '0,
    parameter logic [WIDTH-1:0] B0      = WIDTH'(1),
    parameter int               STEP_A  = 1,
    parameter int               STEP_B  = 3,
    parameter logic [WIDTH-1:0] EXP_SIG = '0
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    localparam int IDX_W = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_q, b_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] alu_r, r_q, sig_q, sig_nxt;
    logic             alu_c, carry_q, zero_q, r_valid_q, flag_q;
    logic             accept, last_vec;

    assign accept   = (state == IDLE) && bus.start;
    assign last_vec = (idx == IDX_W'(NUM_VEC - 1));
    assign sig_nxt  = {sig_q[WIDTH-2:0], sig_q[WIDTH-1]} ^ r_q;

    alu_core #(.WIDTH(WIDTH)) u_alu (
        .A     (a_q),
        .B     (b_q),
        .OP    (op_q),
        .R     (alu_r),
        .carry (alu_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_vec && op_q == OP_ROL) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand generator: the index wrap also rewinds A/B and advances the opcode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx  <= '0;
            a_q  <= A0;
            b_q  <= B0;
            op_q <= OP_ADD;
        end else if (accept) begin
            idx  <= '0;
            a_q  <= A0;
            b_q  <= B0;
            op_q <= OP_ADD;
        end else if (state == RUN) begin
            if (last_vec) begin
                idx  <= '0;
                a_q  <= A0;
                b_q  <= B0;
                op_q <= op_q + 2'd1;
            end else begin
                idx  <= idx + IDX_W'(1);
                a_q  <= a_q + WIDTH'(STEP_A);
                b_q  <= b_q + WIDTH'(STEP_B);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q       <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
            r_valid_q <= 1'b0;
        end else begin
            r_valid_q <= (state == RUN);
            if (state == RUN) begin
                r_q     <= alu_r;
                carry_q <= alu_c;
                zero_q  <= (alu_r == '0);
            end
        end
    end

    // The final result registers during DRAIN, so the flag compares the post-fold signature.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_q  <= '0;
            flag_q <= 1'b0;
        end else if (accept) begin
            sig_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            if (r_valid_q)        sig_q  <= sig_nxt;
            if (state == DRAIN)   flag_q <= (sig_nxt == EXP_SIG);
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.done    = (state == DONE);
    assign bus.A       = a_q;
    assign bus.B       = b_q;
    assign bus.OP      = op_q;
    assign bus.R       = r_q;
    assign bus.r_valid = r_valid_q;
    assign bus.carry   = carry_q;
    assign bus.zero    = zero_q;
    assign bus.sig     = sig_q;
    assign bus.flag    = flag_q;
endmodule

// File: doc/alu_seq_top.md
Name: alu_seq_top

Overview:
- Parametrised successor of the 7-bit controller+ALU top.
- On a start pulse it sweeps every opcode over NUM_VEC generated operand pairs and feeds each pair to a WIDTH-bit ALU core.
- It outputs each registered result with valid and status flags, folds all results into a rotating signature, and raises a pass flag when the signature equals EXP_SIG.
- Used as a self-test/demo top and as the result source for downstream checkers.

Parameters:
- WIDTH, 7, operand/result width (>=2).
- NUM_VEC, 16, vectors per opcode (>=1).
- A0, 0, initial A operand for each opcode sweep (WIDTH bits).
- B0, 1, initial B operand for each opcode sweep (WIDTH bits).
- STEP_A, 1, added to A after each vector, mod 2^WIDTH.
- STEP_B, 3, added to B after each vector, mod 2^WIDTH.
- EXP_SIG, 0, expected final signature (WIDTH bits).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- busy  out  1  high from the cycle after accepted start through the DONE cycle.
- done  out  1  one-cycle pulse at end of sweep.
- A  out  WIDTH  current operand A presented to ALU.
- B  out  WIDTH  current operand B.
- OP  out  2  current opcode: 00 ADD, 01 SUB, 10 NAND, 11 ROL.
- R  out  WIDTH  registered result.
- r_valid  out  1  R/carry/zero valid this cycle.
- carry  out  1  registered carry/borrow.
- zero  out  1  registered (R==0).
- sig  out  WIDTH  running signature.
- flag  out  1  registered (sig==EXP_SIG); meaningful when done=1, held until next start.

Behaviour:
- Reset (rst=0, async): state=IDLE; A=A0, B=B0, OP=00, vector index=0; R=0, carry=0, zero=0, r_valid=0, sig=0, flag=0, busy=0, done=0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 -> RUN next cycle. sig and flag clear, A=A0, B=B0, OP=00, idx=0.
- RUN: one vector presented per cycle.
  - Each cycle: idx+1, A+=STEP_A, B+=STEP_B.
  - At idx==NUM_VEC-1: idx=0, A=A0, B=B0, OP+1.
  - At idx==NUM_VEC-1 and OP==11: -> DRAIN.
- DRAIN: one cycle for the last result to register -> DONE.
- DONE: done=1, flag valid, busy=1 -> IDLE.
- Result latency: 1 cycle. Vector presented in RUN cycle t gives r_valid=1 with its R/carry/zero at t+1.
- Timing: start accepted at edge 0 -> RUN cycles 1..4*NUM_VEC, r_valid cycles 2..4*NUM_VEC+1, done at cycle 4*NUM_VEC+2.
- ALU (combinational core):
  - ADD: R=(A+B) mod 2^WIDTH, carry=carry-out.
  - SUB: R=(A-B) mod 2^WIDTH, carry=borrow (A<B).
  - NAND: R=~(A&B), carry=0.
  - ROL: R=A rotated left by (B mod WIDTH), carry=0.
- Signature, on each r_valid cycle: sig <= rol1(sig) ^ R.
- flag computed in DRAIN->DONE transition from final sig.
- start while busy: ignored, no effect.
- start in DONE cycle: ignored; accepted only in IDLE.
- Async reset mid-sweep: immediate return to reset values; partial signature discarded.
- A/B wrap modulo 2^WIDTH silently.

Decomposition:
- Package alu_seq_pkg: opcode localparams (OP_ADD, OP_SUB, OP_NAND, OP_ROL), state encoding (IDLE, RUN, DRAIN, DONE).
- Sub-module alu_core: purely combinational, parameter WIDTH; inputs A, B, OP; outputs R, carry. Instantiated once.
- Sequencer, result registers and signature live in alu_seq_top.

Test Plan:
- WIDTH=7, NUM_VEC=1, A0=7F, B0=01, start at cycle 0:
  - ADD R=00 carry=1 zero=1
  - SUB R=7E carry=0
  - NAND R=7E
  - ROL R=7F
  - sig=79, done=1 at cycle 6.
- Same config with EXP_SIG=79 -> flag=1 at done. With EXP_SIG=00 -> flag=0.
- Directed alu_core checks, WIDTH=7:
  - SUB 05-07 -> 7E carry=1.
  - ROL A=41 B=09 -> 06.
  - NAND 7F,7F -> 00 zero=1.
- Default params:
  - r_valid high exactly 64 cycles.
  - done at cycle 66.
  - start pulses during busy ignored.
  - Sig matches reference model.
- Drop rst at cycle 20 of a sweep:
  - All outputs return to reset values asynchronously.
  - After release, a new start reproduces the full-run signature.
- Back-to-back sweeps:
  - start held high through DONE -> second sweep accepted only on the IDLE cycle after DONE.
  - sig cleared at acceptance, identical final sig.
